lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 183 ++++++++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32 load/store unit: accepts one core request at a time, performs a single
// word-aligned bus transaction, and returns a lane-extracted, extended load result.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_wen,
    input  logic [2:0]  mem_wr_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] SEL_B    = 3'b000;
    localparam logic [2:0] SEL_H    = 3'b001;
    localparam logic [2:0] SEL_W    = 3'b010;
    localparam logic [2:0] SEL_BAD0 = 3'b011;
    localparam logic [2:0] SEL_BU   = 3'b100;
    localparam logic [2:0] SEL_HU   = 3'b101;
    localparam logic [2:0] SEL_BAD1 = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;

    state_t      state;
    logic        wen_p0;
    logic [2:0]  sel_p0;
    logic [1:0]  lo_p0;

    function automatic logic is_invalid(input logic [2:0] sel);
        return (sel == SEL_BAD0) || (sel == SEL_BAD1);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
        logic m;
        case (sel)
            SEL_H, SEL_HU: m = lo[0];
            SEL_W:         m = |lo;
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [2:0] sel, input logic [1:0] lo);
        logic [3:0] s;
        case (sel)
            SEL_B, SEL_BU: s = 4'b0001 << lo;
            SEL_H, SEL_HU: s = 4'b0011 << lo;
            SEL_W:         s = 4'b1111;
            default:       s = 4'b0000;
        endcase
        return s;
    endfunction

    // Replicating the datum across lanes lets the strobes alone pick the target bytes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] sel, input logic [31:0] wd);
        logic [31:0] d;
        case (sel)
            SEL_B, SEL_BU: d = {4{wd[7:0]}};
            SEL_H, SEL_HU: d = {2{wd[15:0]}};
            default:       d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] sel, input logic [1:0] lo,
                                                 input logic [31:0] rd);
        logic        [31:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        sh = rd >> {lo, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (sel)
            SEL_B:   r = b;
            SEL_H:   r = h;
            SEL_BU:  r = {24'd0, sh[7:0]};
            SEL_HU:  r = {16'd0, sh[15:0]};
            SEL_W:   r = sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rdata         <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= '0;
            mem_wdata     <= '0;
            wen_p0        <= 1'b0;
            sel_p0        <= '0;
            lo_p0         <= '0;
        end else begin
            case (state)
                // ---- IDLE: accept and classify the request
                IDLE: begin
                    if (req_valid) begin
                        wen_p0    <= mem_wen;
                        sel_p0    <= mem_wr_sel;
                        lo_p0     <= addr[1:0];
                        req_ready <= 1'b0;
                        if (is_invalid(mem_wr_sel) || is_misaligned(mem_wr_sel, addr[1:0])) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rdata     <= '0;
                        end else if (mem_wr_sel == SEL_NONE) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rdata     <= '0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {addr[31:2], 2'b00};
                            mem_we        <= mem_wen;
                            mem_wstrb     <= mem_wen ? lane_strobe(mem_wr_sel, addr[1:0]) : 4'b0000;
                            mem_wdata     <= mem_wen ? lane_wdata(mem_wr_sel, wdata) : 32'd0;
                        end
                    end
                end
                // ---- REQ: hold the bus request until it is taken
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_wstrb     <= 4'b0000;
                    end
                end
                // ---- WAIT: capture the bus response
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rdata     <= wen_p0 ? 32'd0 : load_extract(sel_p0, lo_p0, mem_rdata);
                    end
                end
                // ---- DONE: present the result until the core takes it
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rdata     <= '0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized bench for lsu with a byte-lane reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_wen;
    logic [2:0]  mem_wr_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .mem_wen       (mem_wen),
        .mem_wr_sel    (mem_wr_sel),
        .addr          (addr),
        .wdata         (wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rdata         (rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: an access of n bytes at byte offset idx; lane i of store data
    // carries byte (i mod n); loads take n bytes starting at idx and extend.
    function automatic void model(input logic wen, input logic [2:0] sel,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd,
                                  output logic err, output logic bus,
                                  output logic [3:0] strb, output logic [31:0] mwd,
                                  output logic [31:0] res);
        int     n;
        int     idx;
        bit     noop;
        bit     sgn;
        longint v;
        longint lim;
        n = 0; noop = 0; sgn = 0;
        case (sel)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            3'd7: noop = 1;
            default: n = 0;
        endcase
        idx  = int'(a % 4);
        err  = !noop && ((n == 0) || ((idx % n) != 0));
        bus  = !noop && !err;
        strb = '0;
        mwd  = '0;
        res  = '0;
        if (bus && wen) begin
            strb = 4'(((1 << n) - 1) << idx);
            for (int i = 0; i < 4; i++)
                mwd[8*i +: 8] = 8'(wd >> (8 * (i % n)));
        end
        if (bus && !wen) begin
            lim = longint'(1) << (8 * n);
            v   = longint'(rd >> (8 * idx)) % lim;
            if (sgn && v >= lim / 2)
                v = v - lim;
            res = 32'(v);
        end
    endfunction

    // Entered one step after a rising edge with the DUT idle; leaves it idle.
    task automatic do_txn(input logic wen, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rq_dly, input int rs_dly, input int rr_dly);
        logic        e_err, e_bus;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd;
        model(wen, sel, a, wd, rd, e_err, e_bus, e_strb, e_wd, e_rd);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        mem_wen    = wen;
        mem_wr_sel = sel;
        addr       = a;
        wdata      = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        mem_wen    = 1'($urandom);
        mem_wr_sel = 3'($urandom);
        addr       = $urandom;
        wdata      = $urandom;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        if (!e_bus) begin
            chk("nobus_mem_req_valid", 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i <= rq_dly; i++) begin
                chk("req_mem_req_valid", 32'(mem_req_valid), 32'd1);
                chk("req_mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("req_mem_we", 32'(mem_we), 32'(wen));
                chk("req_mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                if (wen) chk("req_mem_wdata", mem_wdata, e_wd);
                chk("req_rsp_valid", 32'(rsp_valid), 32'd0);
                if (i == rq_dly) begin
                    mem_req_ready = 1'b1;
                    mem_rsp_valid = 1'b0;
                end else begin
                    mem_req_ready = 1'b0;
                    mem_rsp_valid = 1'($urandom_range(0, 1));
                    mem_rdata     = $urandom;
                end
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            for (int i = 0; i <= rs_dly; i++) begin
                chk("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
                chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                if (i == rs_dly) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rd;
                end
                @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
        end
        for (int i = 0; i <= rr_dly; i++) begin
            chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("done_rsp_err", 32'(rsp_err), 32'(e_err));
            chk("done_rdata", rdata, e_rd);
            chk("done_req_ready", 32'(req_ready), 32'd0);
            chk("done_mem_req_valid", 32'(mem_req_valid), 32'd0);
            if (i == rr_dly) begin
                rsp_ready  = 1'b1;
                req_valid  = 1'b1;
                mem_wr_sel = 3'b111;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({pfx, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({pfx, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({pfx, "_rdata"}, rdata, 32'd0);
        chk({pfx, "_mem_addr"}, mem_addr, 32'd0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        mem_wen       = 1'b0;
        mem_wr_sel    = 3'b000;
        addr          = '0;
        wdata         = '0;
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // lb sign extension from the top lane
        do_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        // sh into the upper half
        do_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 0);
        // misaligned lw
        do_txn(1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0);
        // lhu with request and response backpressure
        do_txn(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 5, 0, 3);
        // no-op and invalid codes
        do_txn(1'b1, 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 0, 0, 1);
        do_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0);
        do_txn(1'b1, 3'b110, 32'h0000_0004, 32'h0, 32'h0, 0, 0, 0);
        // misaligned half store, byte store at odd offset
        do_txn(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234, 32'h0, 0, 0, 0);
        do_txn(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'h0, 1, 2, 0);

        // reset while waiting for the bus response
        req_valid  = 1'b1;
        mem_wen    = 1'b0;
        mem_wr_sel = 3'b010;
        addr       = 32'h0000_0100;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("wait_before_reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("late_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_rsp_req_ready", 32'(req_ready), 32'd1);
        chk("late_rsp_rdata", rdata, 32'd0);
        do_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
